// File: rtl/alu_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : alu_seq_pkg                                                      |
// | Shared encodings for the sequential ALU: function codes, post-shift        |
// | controls, iterative-core operation kinds and the control FSM states.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package alu_seq_pkg;

  // Function codes carried on funct
  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_SUB  = 1;
  localparam int unsigned ALU_AND  = 2;
  localparam int unsigned ALU_OR   = 3;
  localparam int unsigned ALU_XOR  = 4;
  localparam int unsigned ALU_NOT  = 5;
  localparam int unsigned ALU_PSST = 6;
  localparam int unsigned ALU_PSSY = 7;
  localparam int unsigned ALU_SHL  = 8;
  localparam int unsigned ALU_SHR  = 9;
  localparam int unsigned ALU_SAR  = 10;
  localparam int unsigned ALU_MUL  = 11;

  // Post-shift encodings carried on shiftCtrl
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_SHL1 = 2'b01;
  localparam logic [1:0] SH_SHR1 = 2'b10;
  localparam logic [1:0] SH_SAR1 = 2'b11;

  // Iterative-core operation kinds; these equal funct[1:0] of codes 8..11
  localparam logic [1:0] IT_SHL = 2'b00;
  localparam logic [1:0] IT_SHR = 2'b01;
  localparam logic [1:0] IT_SAR = 2'b10;
  localparam logic [1:0] IT_MUL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_seq_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : alu_seq_unit_if                                                |
// | Request/response bundle of the sequential ALU.                             |
// |   request : in_valid/in_ready, T, Y, funct, shiftCtrl                      |
// |   response: out_valid/out_ready, Result, flagZ/N/C/V, illegal              |
// |   master  : the requester (control unit); slave: the ALU                   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface alu_seq_unit_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int FUNCT_WIDTH = 5
);
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  T;
  logic [DATA_WIDTH-1:0]  Y;
  logic [FUNCT_WIDTH-1:0] funct;
  logic [1:0]             shiftCtrl;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  Result;
  logic                   flagZ;
  logic                   flagN;
  logic                   flagC;
  logic                   flagV;
  logic                   illegal;

  modport master (
    output in_valid, T, Y, funct, shiftCtrl, out_ready,
    input  in_ready, out_valid, Result, flagZ, flagN, flagC, flagV, illegal
  );

  modport slave (
    input  in_valid, T, Y, funct, shiftCtrl, out_ready,
    output in_ready, out_valid, Result, flagZ, flagN, flagC, flagV, illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_iter_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_iter_core                                                    |
// | Bit-serial datapath for variable shifts (one position per step) and        |
// | unsigned shift-add multiply (one multiplier bit per step).                 |
// |   i_load     : capture operands, kind and step count                       |
// |   i_step     : advance one iteration                                       |
// |   o_acc_nxt  : accumulator value after the current step                    |
// |   o_carry_nxt: last bit shifted out after the current step (0 for MUL)     |
// |   o_last     : the current step is the final one                           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module alu_iter_core
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  wire                  clk,
  input  wire                  rst_n,
  input  wire                  i_load,
  input  wire                  i_step,
  input  wire [1:0]            i_kind,
  input  wire [DATA_WIDTH-1:0] i_t,
  input  wire [DATA_WIDTH-1:0] i_y,
  input  wire [CNT_WIDTH-1:0]  i_cnt_init,
  output logic [DATA_WIDTH-1:0] o_acc_nxt,
  output logic                 o_carry_nxt,
  output logic                 o_last
);

  logic [1:0]            r_kind;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_mplier;
  logic                  r_carry;

  // Next accumulator/carry are exposed so the caller can capture the final
  // value on the same edge that performs the last step.
  always_comb begin
    o_acc_nxt   = r_acc;
    o_carry_nxt = r_carry;
    case (r_kind)
      IT_SHL: begin
        o_acc_nxt   = {r_acc[DATA_WIDTH-2:0], 1'b0};
        o_carry_nxt = r_acc[DATA_WIDTH-1];
      end
      IT_SHR: begin
        o_acc_nxt   = {1'b0, r_acc[DATA_WIDTH-1:1]};
        o_carry_nxt = r_acc[0];
      end
      IT_SAR: begin
        o_acc_nxt   = {r_acc[DATA_WIDTH-1], r_acc[DATA_WIDTH-1:1]};
        o_carry_nxt = r_acc[0];
      end
      default: begin
        o_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
      end
    endcase
  end

  assign o_last = (r_cnt == CNT_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kind   <= IT_SHL;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_carry  <= 1'b0;
    end else if (i_load) begin
      r_kind   <= i_kind;
      r_cnt    <= i_cnt_init;
      r_acc    <= (i_kind == IT_MUL) ? '0 : i_t;
      r_mcand  <= i_t;
      r_mplier <= i_y;
      r_carry  <= 1'b0;
    end else if (i_step) begin
      r_cnt    <= r_cnt - CNT_WIDTH'(1);
      r_acc    <= o_acc_nxt;
      r_carry  <= o_carry_nxt;
      r_mcand  <= {r_mcand[DATA_WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[DATA_WIDTH-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_seq_unit                                                     |
// | Sequential ALU for the Forth core datapath. Logic/add ops finish in one    |
// | cycle; variable shifts and multiply run on alu_iter_core. A post-shift     |
// | is applied to the core result and Result/flags are registered.            |
// |   clk, rst_n : clock, asynchronous active-low reset                        |
// |   bus        : alu_seq_unit_if.slave (request + response handshakes)       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FUNCT_WIDTH = 5,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input wire            clk,
  input wire            rst_n,
  alu_seq_unit_if.slave bus
);

  localparam int c_CNT_WIDTH = SHAMT_WIDTH + 1;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [1:0]            r_shctl;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_z, r_n, r_c, r_v, r_illegal;

  logic [31:0]            w_fcode;
  logic                   w_accept;
  logic [SHAMT_WIDTH-1:0] w_shamt;
  logic                   w_goes_iter;
  logic [c_CNT_WIDTH-1:0] w_cnt_init;

  logic [DATA_WIDTH:0]   w_sum, w_diff;
  logic [DATA_WIDTH-1:0] w_alu_res;
  logic                  w_alu_c, w_alu_v, w_alu_ill;

  logic [DATA_WIDTH-1:0] w_core_acc_nxt;
  logic                  w_core_carry_nxt, w_core_last;

  logic [DATA_WIDTH-1:0] w_fin_res, w_ps;
  logic [1:0]            w_fin_sh;
  logic                  w_fin_c, w_fin_v, w_fin_ill, w_load_out;

  assign w_fcode  = 32'(bus.funct);
  assign w_accept = bus.in_valid && (r_state == S_IDLE);
  assign w_shamt  = bus.Y[SHAMT_WIDTH-1:0];

  // A shift by zero needs no iterations, so it completes like a one-cycle op.
  assign w_goes_iter = (w_fcode == ALU_MUL) ||
                       ((w_fcode >= ALU_SHL) && (w_fcode <= ALU_SAR) && (w_shamt != '0));
  assign w_cnt_init  = (w_fcode == ALU_MUL) ? c_CNT_WIDTH'(DATA_WIDTH)
                                            : {1'b0, w_shamt};

  // Single-cycle ALU, evaluated on the live request at the accept edge
  assign w_sum  = {1'b0, bus.T} + {1'b0, bus.Y};
  assign w_diff = {1'b0, bus.T} - {1'b0, bus.Y};

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    w_alu_ill = 1'b0;
    case (w_fcode)
      ALU_ADD: begin
        w_alu_res = w_sum[DATA_WIDTH-1:0];
        w_alu_c   = w_sum[DATA_WIDTH];
        w_alu_v   = (bus.T[DATA_WIDTH-1] == bus.Y[DATA_WIDTH-1]) &&
                    (w_sum[DATA_WIDTH-1] != bus.T[DATA_WIDTH-1]);
      end
      ALU_SUB: begin
        w_alu_res = w_diff[DATA_WIDTH-1:0];
        w_alu_c   = ~w_diff[DATA_WIDTH];   // no borrow means T >= Y
        w_alu_v   = (bus.T[DATA_WIDTH-1] != bus.Y[DATA_WIDTH-1]) &&
                    (w_diff[DATA_WIDTH-1] != bus.T[DATA_WIDTH-1]);
      end
      ALU_AND:  w_alu_res = bus.T & bus.Y;
      ALU_OR:   w_alu_res = bus.T | bus.Y;
      ALU_XOR:  w_alu_res = bus.T ^ bus.Y;
      ALU_NOT:  w_alu_res = ~bus.T;
      ALU_PSST: w_alu_res = bus.T;
      ALU_PSSY: w_alu_res = bus.Y;
      ALU_SHL, ALU_SHR, ALU_SAR: w_alu_res = bus.T;  // zero-distance case
      ALU_MUL:  w_alu_res = '0;                        // always iterative
      default:  w_alu_ill = 1'b1;
    endcase
  end

  alu_iter_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (c_CNT_WIDTH)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_accept && w_goes_iter),
    .i_step      (r_state == S_ITER),
    .i_kind      (bus.funct[1:0]),
    .i_t         (bus.T),
    .i_y         (bus.Y),
    .i_cnt_init  (w_cnt_init),
    .o_acc_nxt   (w_core_acc_nxt),
    .o_carry_nxt (w_core_carry_nxt),
    .o_last      (w_core_last)
  );

  // Pick the finishing source: the iterative core in ITER, the live ALU in IDLE.
  // shiftCtrl comes from the latched copy once the request has left the bus.
  always_comb begin
    w_fin_res = w_alu_res;
    w_fin_c   = w_alu_c;
    w_fin_v   = w_alu_v;
    w_fin_ill = w_alu_ill;
    w_fin_sh  = bus.shiftCtrl;
    if (r_state == S_ITER) begin
      w_fin_res = w_core_acc_nxt;
      w_fin_c   = w_core_carry_nxt;
      w_fin_v   = 1'b0;
      w_fin_ill = 1'b0;
      w_fin_sh  = r_shctl;
    end
  end

  always_comb begin
    w_ps = w_fin_res;
    case (w_fin_sh)
      SH_SHL1: w_ps = {w_fin_res[DATA_WIDTH-2:0], 1'b0};
      SH_SHR1: w_ps = {1'b0, w_fin_res[DATA_WIDTH-1:1]};
      SH_SAR1: w_ps = {w_fin_res[DATA_WIDTH-1], w_fin_res[DATA_WIDTH-1:1]};
      default: w_ps = w_fin_res;
    endcase
  end

  assign w_load_out = (w_accept && !w_goes_iter) ||
                      ((r_state == S_ITER) && w_core_last);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid)  w_state_nxt = w_goes_iter ? S_ITER : S_DONE;
      S_ITER:  if (w_core_last)   w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_shctl   <= SH_NONE;
      r_result  <= '0;
      r_z       <= 1'b0;
      r_n       <= 1'b0;
      r_c       <= 1'b0;
      r_v       <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_shctl <= bus.shiftCtrl;
      if (w_load_out) begin
        r_result  <= w_ps;
        r_z       <= (w_ps == '0);
        r_n       <= w_ps[DATA_WIDTH-1];
        r_c       <= w_fin_c;
        r_v       <= w_fin_v;
        r_illegal <= w_fin_ill;
      end
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.Result    = r_result;
  assign bus.flagZ     = r_z;
  assign bus.flagN     = r_n;
  assign bus.flagC     = r_c;
  assign bus.flagV     = r_v;
  assign bus.illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_alu_seq_unit                                                  |
// | Scoreboard bench for alu_seq_unit: a 16-bit instance driven with directed  |
// | vectors and a 32-bit instance for the wide shift case.                     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_alu_seq_unit;

  typedef struct {
    string       nm;
    logic [31:0] res;
    logic        z, n, c, v, ill;
    int          lat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0, acc_cyc = 0, acc32_cyc = 0;
  int   n_tests = 0, n_fail = 0;
  exp_t sb[$];
  exp_t sb32[$];
  exp_t m_e, m32_e;
  logic        prev_v = 1'b0;
  logic [15:0] snap   = '0;

  alu_seq_unit_if #(.DATA_WIDTH(16), .FUNCT_WIDTH(5)) bus ();
  alu_seq_unit_if #(.DATA_WIDTH(32), .FUNCT_WIDTH(5)) bus32 ();

  alu_seq_unit #(.DATA_WIDTH(16), .FUNCT_WIDTH(5), .SHAMT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  alu_seq_unit #(.DATA_WIDTH(32), .FUNCT_WIDTH(5), .SHAMT_WIDTH(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(bus32));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endfunction

  // Monitor for the 16-bit unit: latency on the first DONE cycle, stability
  // while stalled, and full compare on the transfer cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (bus.out_valid && !prev_v) begin
        if (sb.size() == 0) chk1("spurious out_valid", bus.out_valid, 1'b0);
        else begin
          chk({sb[0].nm, " latency"}, cyc - acc_cyc, sb[0].lat);
          snap = bus.Result;
        end
      end else if (bus.out_valid && sb.size() != 0) begin
        chk({sb[0].nm, " stable"}, 32'(bus.Result), 32'(snap));
      end
      if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
        m_e = sb.pop_front();
        chk ({m_e.nm, " Result"}, 32'(bus.Result), m_e.res);
        chk1({m_e.nm, " Z"}, bus.flagZ, m_e.z);
        chk1({m_e.nm, " N"}, bus.flagN, m_e.n);
        chk1({m_e.nm, " C"}, bus.flagC, m_e.c);
        chk1({m_e.nm, " V"}, bus.flagV, m_e.v);
        chk1({m_e.nm, " illegal"}, bus.illegal, m_e.ill);
      end
      prev_v = bus.out_valid && !bus.out_ready;
    end
  end

  // Monitor for the 32-bit unit (out_ready held high)
  always @(negedge clk) begin
    if (rst_n && bus32.out_valid) begin
      if (sb32.size() == 0) chk1("w32 spurious out_valid", bus32.out_valid, 1'b0);
      else begin
        m32_e = sb32.pop_front();
        chk ({m32_e.nm, " latency"}, cyc - acc32_cyc, m32_e.lat);
        chk ({m32_e.nm, " Result"}, bus32.Result, m32_e.res);
        chk1({m32_e.nm, " N"}, bus32.flagN, m32_e.n);
        chk1({m32_e.nm, " C"}, bus32.flagC, m32_e.c);
      end
    end
  end

  task automatic issue(input logic [15:0] t, input logic [15:0] y, input logic [4:0] f,
                       input logic [1:0] sc, input string nm, input logic [15:0] res,
                       input logic z, input logic n, input logic c, input logic v,
                       input logic ill, input int lat);
    exp_t e;
    bit   ok;
    e.nm = nm; e.res = {16'h0, res};
    e.z = z; e.n = n; e.c = c; e.v = v; e.ill = ill; e.lat = lat;
    ok = 1'b0;
    @(posedge clk); #1;
    sb.push_back(e);
    bus.in_valid = 1'b1; bus.T = t; bus.Y = y; bus.funct = f; bus.shiftCtrl = sc;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc_cyc = cyc;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk1({nm, " accept timeout"}, 1'b0, 1'b1);
    @(posedge clk); #1;
    // Scramble the request after acceptance; the unit must use its latched copy.
    bus.in_valid = 1'b0; bus.T = ~t; bus.Y = ~y; bus.funct = f ^ 5'h15; bus.shiftCtrl = ~sc;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      chk("drain timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.T = '0; bus.Y = '0; bus.funct = '0; bus.shiftCtrl = '0;
    bus.out_ready = 1'b1;
    bus32.in_valid = 1'b0; bus32.T = '0; bus32.Y = '0; bus32.funct = '0;
    bus32.shiftCtrl = '0; bus32.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk1("reset in_ready", bus.in_ready, 1'b1);
    chk1("reset out_valid", bus.out_valid, 1'b0);
    chk ("reset Result", 32'(bus.Result), 32'h0);
    chk ("reset flags", {28'h0, bus.flagZ, bus.flagN, bus.flagC, bus.flagV}, 32'h0);
    chk1("reset illegal", bus.illegal, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    //     T        Y        f      sc     name          Result    Z     N     C     V     ill  lat
    issue(16'h7FFF, 16'h0001, 5'd0, 2'b00, "add ovf",    16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    issue(16'h0005, 16'h0005, 5'd1, 2'b01, "sub eq",     16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    issue(16'hFFFF, 16'h0001, 5'd0, 2'b00, "add carry",  16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    issue(16'h8000, 16'h8000, 5'd0, 2'b10, "add c+v shr",16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    issue(16'h0003, 16'h0005, 5'd1, 2'b00, "sub borrow", 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    issue(16'h8000, 16'h0001, 5'd1, 2'b00, "sub ovf",    16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    issue(16'hF0F0, 16'h3C3C, 5'd2, 2'b00, "and",        16'h3030, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    issue(16'h1200, 16'h0034, 5'd3, 2'b10, "or shr1",    16'h091A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    issue(16'hFFFF, 16'h00FF, 5'd4, 2'b00, "xor",        16'hFF00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    issue(16'h0000, 16'h1234, 5'd5, 2'b11, "not sar1",   16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    issue(16'h8001, 16'h0000, 5'd6, 2'b01, "passT shl1", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    issue(16'h0000, 16'hABCD, 5'd7, 2'b00, "passY",      16'hABCD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    issue(16'h1234, 16'h0010, 5'd8, 2'b00, "shl n=0",    16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    issue(16'h8001, 16'h0001, 5'd9, 2'b01, "shr1 shl1",  16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2);
    issue(16'hC000, 16'h0002, 5'd8, 2'b00, "shl2",       16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3);
    issue(16'hFFFF, 16'hFFFF, 5'd11,2'b00, "mul max",    16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17);
    issue(16'h1234, 16'h5678, 5'd12,2'b01, "funct 12",   16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    drain();

    // SAR with in_ready low throughout the iteration
    issue(16'h8010, 16'h0004, 5'd10, 2'b00, "sar4", 16'hF801, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
      chk1("sar4 in_ready busy", bus.in_ready, 1'b0);
    end
    drain();

    // MUL with a 3-cycle consumer stall and a competing request
    @(posedge clk); #1 bus.out_ready = 1'b0;
    issue(16'h0123, 16'h0010, 5'd11, 2'b00, "mul", 16'h1230, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    chk1("mul out_valid seen", bus.out_valid, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.funct = 5'd0; bus.T = 16'h1111; bus.Y = 16'h2222;
    repeat (3) begin
      @(negedge clk);
      chk1("mul stall in_ready", bus.in_ready, 1'b0);
      chk1("mul stall out_valid", bus.out_valid, 1'b1);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    drain();

    // Illegal code, then reset during a multiply
    issue(16'h5555, 16'hAAAA, 5'h1F, 2'b00, "funct 1F", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    drain();
    issue(16'h0003, 16'h0005, 5'd11, 2'b00, "mul aborted", 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk1("abort out_valid", bus.out_valid, 1'b0);
    chk1("abort in_ready", bus.in_ready, 1'b1);
    chk1("abort illegal", bus.illegal, 1'b0);
    chk1("abort Z", bus.flagZ, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk1("post-abort in_ready", bus.in_ready, 1'b1);

    // 32-bit instance: SHL 1 by 31
    begin
      exp_t e;
      bit   ok;
      e.nm = "w32 shl31"; e.res = 32'h8000_0000; e.z = 1'b0; e.n = 1'b1;
      e.c = 1'b0; e.v = 1'b0; e.ill = 1'b0; e.lat = 32;
      ok = 1'b0;
      @(posedge clk); #1;
      sb32.push_back(e);
      bus32.in_valid = 1'b1; bus32.T = 32'h1; bus32.Y = 32'd31; bus32.funct = 5'd8;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (bus32.in_ready) begin acc32_cyc = cyc; ok = 1'b1; break; end
      end
      if (!ok) chk1("w32 accept timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
      bus32.in_valid = 1'b0; bus32.T = '0; bus32.Y = '0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (sb32.size() == 0) break;
      end
      if (sb32.size() != 0) begin
        chk("w32 drain timeout", sb32.size(), 0);
        sb32.delete();
      end
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
